// File: rtl/jesd_rx_sample_fifo.sv
// jesd_rx_sample_fifo
//
// JESD204B RX transport stage. It takes the descrambled, lane-aligned word stream from the link
// layer and byte-swaps each octet pair into a 16-bit converter sample, with the even octet as the
// MSB. The stream starts on the first start-of-multiframe word. Words are buffered in a
// first-word-fall-through FIFO and presented as an AXI4-Stream master.
//
// Ports:
//   clk, rst          link clock, asynchronous active-high reset
//   enable            low forces IDLE and flushes the FIFO
//   rx_data/rx_valid  lane words from the link layer (lane l at [32l+:32], octet 0 in [7:0])
//   rx_somf/rx_eomf   per-octet-position start/end-of-multiframe markers
//   m_axis_*          sample stream (tuser = start of multiframe, tlast = end of multiframe)
//   overflow          sticky: a word was dropped because the FIFO was full
//   clear_overflow    synchronous clear of overflow; a set in the same cycle wins
//   frame_cnt         wrapping count of words written to the FIFO
//   state             0 IDLE, 1 ALIGN, 2 RUN
module jesd_rx_sample_fifo #(
  parameter int unsigned L          = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [L*DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic [3:0]            rx_somf,
  input  logic [3:0]            rx_eomf,
  output logic [L*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  overflow,
  input  logic                  clear_overflow,
  output logic [31:0]           frame_cnt,
  output logic [1:0]            state
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned DataW  = L * DATA_WIDTH;
  localparam int unsigned EntryW = DataW + 2;
  localparam bit          LOk    = (L >= 1) && (L <= 4);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAlign = 2'd1,
    StRun   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [31:0]       frame_cnt_q;
  logic              overflow_q;
  logic [EntryW-1:0] mem [DEPTH];

  logic [DataW-1:0]  swapped;
  logic              som, eom, full, empty;
  logic              align_hit, wr_window, wr_en, rd_en, drop, flush;
  logic [EntryW-1:0] head;

  // Big-endian sample order: the first received octet of each pair becomes the MSB.
  always_comb begin
    swapped = '0;
    for (int s = 0; s < 2 * L; s++) begin
      swapped[16*s +: 16] = {rx_data[16*s +: 8], rx_data[16*s+8 +: 8]};
    end
  end

  assign som   = |rx_somf;
  assign eom   = |rx_eomf;
  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

  // The SOMF word that moves ALIGN to RUN is itself the first word written.
  assign align_hit = (state_q == StAlign) && rx_valid && som;
  assign wr_window = enable && rx_valid && ((state_q == StRun) || align_hit);
  // Full is judged on the pre-read count, so a read on the same edge does not rescue the word.
  assign wr_en     = wr_window && !full;
  assign drop      = wr_window && full;
  assign rd_en     = !empty && m_axis_tready;
  assign flush     = !enable || ((state_q == StRun) && !rx_valid);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (rx_valid) state_d = StAlign;
      StAlign: if (rx_valid && som) state_d = StRun;
      StRun:   if (!rx_valid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (!enable) state_d = StIdle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_q + CntW'(wr_en) - CntW'(rd_en);
      end
      if (wr_en) frame_cnt_q <= frame_cnt_q + 32'd1;
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (clear_overflow) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // Storage needs no reset: the outputs are gated by empty, so stale entries never show.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= {swapped, eom, som};
  end

  assign head = mem[rd_ptr_q];

  always_comb begin
    m_axis_tvalid = LOk && !empty;
    m_axis_tdata  = m_axis_tvalid ? head[EntryW-1:2] : '0;
    m_axis_tlast  = m_axis_tvalid && head[1];
    m_axis_tuser  = m_axis_tvalid && head[0];
    overflow      = LOk && overflow_q;
    frame_cnt     = LOk ? frame_cnt_q : 32'd0;
    state         = LOk ? state_q : 2'd0;
  end

endmodule

// File: tb/tb_jesd_rx_sample_fifo.sv
module tb_jesd_rx_sample_fifo;

  localparam int unsigned L     = 2;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned W     = L * 32;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
    logic         user;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst, enable, rx_valid, tready, clear_overflow;
  logic [W-1:0] rx_data;
  logic [3:0]   somf, eomf;
  logic [W-1:0] tdata;
  logic         tvalid, tlast, tuser, overflow;
  logic [31:0]  frame_cnt;
  logic [1:0]   state;

  ent_t         sb[$];
  int           n_vec, n_err;
  logic [31:0]  exp_fc;

  jesd_rx_sample_fifo #(.L(L), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_somf        (somf),
    .rx_eomf        (eomf),
    .m_axis_tdata   (tdata),
    .m_axis_tvalid  (tvalid),
    .m_axis_tready  (tready),
    .m_axis_tlast   (tlast),
    .m_axis_tuser   (tuser),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .frame_cnt      (frame_cnt),
    .state          (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Octet k of the word is d[8k+:8]; sample s = {octet 2s, octet 2s+1}.
  function automatic logic [W-1:0] swap(input logic [W-1:0] d);
    logic [W-1:0] r;
    logic [7:0]   msb, lsb;
    r = '0;
    for (int s = 0; s < 2 * L; s++) begin
      msb = d[8*(2*s) +: 8];
      lsb = d[8*(2*s+1) +: 8];
      r[16*s +: 16] = {msb, lsb};
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [W-1:0] d, input logic [3:0] so, input logic [3:0] eo,
                      input bit wr);
    ent_t e;
    rx_valid = 1'b1;
    rx_data  = d;
    somf     = so;
    eomf     = eo;
    if (wr) begin
      e.data = swap(d);
      e.last = |eo;
      e.user = |so;
      sb.push_back(e);
      exp_fc++;
    end
    tick();
  endtask

  task automatic link_down();
    rx_valid = 1'b0;
    somf     = 4'b0;
    eomf     = 4'b0;
    tick();
    sb.delete();
    check("down_state", state, 2'd0);
    check("down_tvalid", tvalid, 1'b0);
  endtask

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  // Scoreboard: while tvalid is high the head must equal the oldest expected word
  // (which also covers AXI stability); a handshake retires it.
  always @(negedge clk) begin
    if (!rst && tvalid) begin
      if (sb.size() == 0) begin
        check("spurious_tvalid", tvalid, 1'b0);
      end else begin
        check("tdata", tdata, sb[0].data);
        check("tlast", tlast, sb[0].last);
        check("tuser", tuser, sb[0].user);
        if (tready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    n_vec = 0; n_err = 0; exp_fc = '0;
    rst = 1'b1; enable = 1'b0; rx_valid = 1'b0; tready = 1'b0; clear_overflow = 1'b0;
    rx_data = '0; somf = '0; eomf = '0;
    #1;
    check("rst_state", state, 2'd0);
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_tdata", tdata, '0);
    check("rst_tlast", tlast, 1'b0);
    check("rst_tuser", tuser, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_frame_cnt", frame_cnt, 32'd0);
    #20 rst = 1'b0;
    tick();

    // Alignment
    enable = 1'b1;
    tready = 1'b1;
    send(rnd(), 4'b0, 4'b0, 1'b0);
    check("align_state1", state, 2'd1);
    send(rnd(), 4'b0, 4'b0, 1'b0);
    send(rnd(), 4'b0, 4'b0, 1'b0);
    check("align_state_hold", state, 2'd1);
    check("align_no_write", tvalid, 1'b0);
    send({32'h88776655, 32'h44332211}, 4'b0001, 4'b0, 1'b1);
    check("align_state2", state, 2'd2);
    check("align_frame_cnt", frame_cnt, 32'd1);
    check("align_tvalid", tvalid, 1'b1);
    check("align_tuser", tuser, 1'b1);
    check("align_lane0", tdata[31:0], 32'h33441122);
    check("align_lane1", tdata[63:32], 32'h77885566);
    link_down();

    // Streaming: 32 words, one per cycle, tlast on the last
    send(rnd(), 4'b0, 4'b0, 1'b0);
    for (int i = 1; i <= 32; i++) begin
      send(rnd(), (i == 1) ? 4'b0001 : 4'b0, (i == 32) ? 4'b1000 : 4'b0, 1'b1);
    end
    check("stream_backlog", sb.size(), 1);
    check("stream_tlast", tlast, 1'b1);
    check("stream_frame_cnt", frame_cnt, exp_fc);
    link_down();

    // Backpressure / overflow with set-beats-clear on the first drop
    tready = 1'b0;
    send(rnd(), 4'b0, 4'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      clear_overflow = (i == 9);
      send(rnd(), (i == 1) ? 4'b0010 : 4'b0, 4'b0, i <= 8);
      if (i == 8) check("bp_ovf_before", overflow, 1'b0);
      if (i == 9) check("bp_ovf_set_wins", overflow, 1'b1);
    end
    clear_overflow = 1'b0;
    check("bp_tvalid_held", tvalid, 1'b1);
    check("bp_overflow", overflow, 1'b1);
    // Full with read+write on one edge: word 11 is dropped, later words fit again
    tready = 1'b1;
    for (int i = 11; i <= 22; i++) send(rnd(), 4'b0, 4'b0, i >= 12);
    check("bp_ovf_sticky", overflow, 1'b1);
    clear_overflow = 1'b1;
    send(rnd(), 4'b0, 4'b0, 1'b1);
    clear_overflow = 1'b0;
    check("bp_ovf_cleared", overflow, 1'b0);
    check("bp_frame_cnt", frame_cnt, exp_fc);
    tready = 1'b0;
    link_down();

    // Link loss with 3 words buffered, then realignment needs a fresh SOMF
    send(rnd(), 4'b0, 4'b0, 1'b0);
    send(rnd(), 4'b0100, 4'b0, 1'b1);
    send(rnd(), 4'b0, 4'b0, 1'b1);
    send(rnd(), 4'b0, 4'b0, 1'b1);
    link_down();
    for (int i = 0; i < 3; i++) send(rnd(), 4'b0, 4'b0, 1'b0);
    check("realign_state", state, 2'd1);
    check("realign_tvalid", tvalid, 1'b0);
    check("realign_frame_cnt", frame_cnt, exp_fc);
    send(rnd(), 4'b1000, 4'b0, 1'b1);
    check("realign_run", state, 2'd2);
    check("realign_out", tvalid, 1'b1);

    // Async reset between edges with data buffered
    send(rnd(), 4'b0, 4'b0, 1'b1);
    send(rnd(), 4'b0, 4'b0, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("arst_state", state, 2'd0);
    check("arst_tvalid", tvalid, 1'b0);
    check("arst_tdata", tdata, '0);
    check("arst_tuser", tuser, 1'b0);
    check("arst_overflow", overflow, 1'b0);
    check("arst_frame_cnt", frame_cnt, 32'd0);
    sb.delete();
    exp_fc = '0;
    #4 rst = 1'b0;
    tick();
    check("arst_empty", tvalid, 1'b0);
    check("arst_state_align", state, 2'd1);
    send(rnd(), 4'b0001, 4'b0, 1'b1);
    check("arst_frame_cnt_1", frame_cnt, 32'd1);
    check("arst_tvalid_1", tvalid, 1'b1);

    // Disable forces IDLE and flushes
    enable = 1'b0;
    tick();
    sb.delete();
    check("dis_state", state, 2'd0);
    check("dis_tvalid", tvalid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
